fsm_hash2matrix: RTL and testbench
==================================

Name: fsm_hash2matrix

Overview:
Receive-side counterpart of the matrix-to-hash framer.
- Pops framed 64-bit words from the sha3 output FIFO. Each frame is one header word followed by HASH_WORDS data words.
- Validates the header, strips it, and packs the data words into one 256-bit hash word for the matrix input stage.
- Sits between the sha3_out FIFO read port and the matrix-multiply input, with valid/ready backpressure.

Parameters:
DATA_W, 64, FIFO word width
HASH_WORDS, 4, data words per frame; hash_dout width = DATA_W*HASH_WORDS
HDR_WORD, 64'h8000000000000100, expected header: bit63 frame flag, [31:0] payload length in bits (256)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
fifo_empty  in  1  FIFO empty flag; FIFO is first-word-fall-through
fifo_dout  in  64  FIFO head word, valid when fifo_empty=0
fifo_rd_en  out  1  pop strobe; the head word is consumed in the same cycle
hash_valid  out  1  hash_dout holds a complete hash
hash_ready  in  1  downstream accepts the hash when hash_valid & hash_ready
hash_dout  out  256  packed hash; first data word in [255:192], last in [63:0]
hdr_err  out  1  one-cycle pulse per discarded non-header word

Behaviour:
- Reset (async, rst=1): state=READ_HEADER, word counter=0, hash_dout=0, hash_valid=0, fifo_rd_en=0, hdr_err=0. Reset mid-frame discards the partial frame.
- fifo_rd_en is combinational: asserted only when fifo_empty=0 and the current state consumes a word. It is never asserted when fifo_empty=1.
- READ_HEADER, when fifo_empty=0: pop the head word.
  - If it equals HDR_WORD: go to READ_DATA with cnt=0.
  - Otherwise: pulse hdr_err for that cycle, discard the word, stay in READ_HEADER. This is resync: scan until a valid header.
- READ_DATA, when fifo_empty=0: pop the word and write it to hash_dout[DATA_W*(HASH_WORDS-1-cnt) +: DATA_W], then cnt++.
  - The data word is not checked. A word equal to HDR_WORD in this state is data.
  - When cnt==HASH_WORDS-1 is popped: go to OUTPUT on the next cycle and register hash_valid=1.
  - fifo_empty=1: hold state and cnt (bubbles allowed).
- OUTPUT: hash_valid=1 and hash_dout held stable; no FIFO pops.
  - hash_valid & hash_ready: clear hash_valid on the next edge and return to READ_HEADER.
  - hash_ready may be held high indefinitely. hash_valid must never drop without a handshake.
- Throughput: minimum frame period is HASH_WORDS+2 cycles (header pop, 4 data pops, 1 output cycle).
- Latency: hash_valid rises 1 cycle after the last data word is popped.
- hash_dout bits change only in READ_DATA.

Optional Feature:
HASH2MATRIX_SKID_EN
- Defined: adds a 256-bit output holding register with its own valid bit, decoupling assembly from output.
  - On frame completion, the assembly buffer copies into the output register if it is empty or is being accepted in the same cycle, and the FSM returns to READ_HEADER immediately.
  - If the output register is full and not being accepted, the FSM waits in OUTPUT.
  - Minimum frame period becomes HASH_WORDS+1 cycles. Popping during an output stall is allowed.
- Undefined: behaviour exactly as above (single buffer, no pops while hash_valid=1).

Decomposition:
- Package fsm_hash2matrix_pkg holds:
  - state enum {READ_HEADER, READ_DATA, OUTPUT}
  - HDR_WORD, DATA_W and HASH_WORDS defaults
  - HASH_W = DATA_W*HASH_WORDS
  - counter width $clog2(HASH_WORDS)
- Shared with the framer so both ends use one header constant.
- One natural sub-module: hash_out_reg, the valid/ready holding register. It is instantiated only under HASH2MATRIX_SKID_EN.

Test Plan:
- Single frame, FIFO always non-empty, hash_ready=1:
  - Stimulus: header, then 0x1111..., 0x2222..., 0x3333..., 0x4444...
  - Required: hash_dout = {0x1111...,0x2222...,0x3333...,0x4444...}, hash_valid for exactly 1 cycle, 5 pops.
- Bad header:
  - Stimulus: 0xDEADBEEF00000000, then a valid frame.
  - Required: one hdr_err pulse, the word is discarded, the following frame is assembled correctly.
- Backpressure:
  - Stimulus: hash_ready=0 for 10 cycles after completion, next frame already queued.
  - Required without SKID: hash_valid and hash_dout stable, fifo_rd_en=0 throughout.
  - Required with SKID: the next frame's 5 words are popped and it is held until the first hash is accepted.
- FIFO bubbles:
  - Stimulus: fifo_empty toggled every other cycle mid-frame.
  - Required: no pop while empty, correct word ordering, cnt held.
- Reset mid-frame:
  - Stimulus: rst asserted asynchronously after 2 data words, then a full frame.
  - Required: outputs zero immediately; the next frame is assembled with no remnants of the partial frame.
- Back-to-back frames:
  - Stimulus: 3 frames, hash_ready=1.
  - Required: 3 hashes, spaced 6 cycles apart without SKID and 5 cycles apart with SKID.

Source files
------------

// File: rtl/fsm_hash2matrix_pkg.sv
// Shared constants and types for the hash-to-matrix deframer and its framer.
package fsm_hash2matrix_pkg;

  localparam int unsigned DATA_W     = 64;
  localparam int unsigned HASH_WORDS = 4;
  localparam int unsigned HASH_W     = DATA_W * HASH_WORDS;
  localparam int unsigned CNT_W      = (HASH_WORDS > 1) ? $clog2(HASH_WORDS) : 1;

  // bit63 frame flag, [31:0] payload length in bits
  localparam logic [DATA_W-1:0] HDR_WORD = 64'h8000000000000100;

  typedef enum logic [1:0] {
    READ_HEADER,
    READ_DATA,
    OUTPUT
  } state_t;

endpackage

// File: rtl/fsm_hash2matrix_hash_out_reg.sv
// Valid/ready output holding register, used by the deframer when HASH2MATRIX_SKID_EN is defined.
module hash_out_reg
  import fsm_hash2matrix_pkg::*;
#(
  parameter int unsigned W = HASH_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] din,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] dout
);

  // load is only raised when the register is empty or being accepted this cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      dout  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      dout  <= din;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fsm_hash2matrix.sv
// Deframer: pops header+data words from the sha3_out FIFO and packs them into one hash word.
// Optional output skid register: define HASH2MATRIX_SKID_EN.
module fsm_hash2matrix
  import fsm_hash2matrix_pkg::*;
#(
  parameter int unsigned       DATA_W     = fsm_hash2matrix_pkg::DATA_W,
  parameter int unsigned       HASH_WORDS = fsm_hash2matrix_pkg::HASH_WORDS,
  parameter logic [DATA_W-1:0] HDR_WORD   = fsm_hash2matrix_pkg::HDR_WORD
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         fifo_empty,
  input  logic [DATA_W-1:0]            fifo_dout,
  output logic                         fifo_rd_en,
  output logic                         hash_valid,
  input  logic                         hash_ready,
  output logic [DATA_W*HASH_WORDS-1:0] hash_dout,
  output logic                         hdr_err
);

  localparam int unsigned HW    = DATA_W * HASH_WORDS;
  localparam int unsigned CW    = (HASH_WORDS > 1) ? $clog2(HASH_WORDS) : 1;
  localparam logic [CW-1:0] LAST = CW'(HASH_WORDS - 1);

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [HW-1:0]   asm_q, asm_nxt;
  logic            can_pop;

  // Popping is also gated by rst so the FIFO is never drained while held in reset
  assign can_pop = !fifo_empty && !rst;

`ifdef HASH2MATRIX_SKID_EN
  logic load;
  logic out_free;

  assign out_free = !hash_valid || hash_ready;

  hash_out_reg #(
    .W (HW)
  ) u_out_reg (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .din   (asm_nxt),
    .ready (hash_ready),
    .valid (hash_valid),
    .dout  (hash_dout)
  );
`else
  logic valid_nxt;

  assign hash_dout = asm_q;
`endif

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    asm_nxt    = asm_q;
    fifo_rd_en = 1'b0;
    hdr_err    = 1'b0;
`ifdef HASH2MATRIX_SKID_EN
    load       = 1'b0;
`else
    valid_nxt  = hash_valid;
`endif
    case (state)
      READ_HEADER: begin
        if (can_pop) begin
          fifo_rd_en = 1'b1;
          if (fifo_dout == HDR_WORD) begin
            state_nxt = READ_DATA;
            cnt_nxt   = '0;
          end else begin
            hdr_err = 1'b1;
          end
        end
      end
      READ_DATA: begin
        if (can_pop) begin
          fifo_rd_en = 1'b1;
          for (int unsigned i = 0; i < HASH_WORDS; i++) begin
            if (CW'(HASH_WORDS - 1 - i) == cnt) asm_nxt[DATA_W*i +: DATA_W] = fifo_dout;
          end
          if (cnt == LAST) begin
            cnt_nxt = '0;
`ifdef HASH2MATRIX_SKID_EN
            // the completed word (including this last slot) goes straight to the output register
            if (out_free) begin
              load      = 1'b1;
              state_nxt = READ_HEADER;
            end else begin
              state_nxt = OUTPUT;
            end
`else
            state_nxt = OUTPUT;
            valid_nxt = 1'b1;
`endif
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
      end
      OUTPUT: begin
`ifdef HASH2MATRIX_SKID_EN
        if (out_free) begin
          load      = 1'b1;
          state_nxt = READ_HEADER;
        end
`else
        if (hash_ready) begin
          valid_nxt = 1'b0;
          state_nxt = READ_HEADER;
        end
`endif
      end
      default: state_nxt = READ_HEADER;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= READ_HEADER;
      cnt   <= '0;
      asm_q <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      asm_q <= asm_nxt;
    end
  end

`ifndef HASH2MATRIX_SKID_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) hash_valid <= 1'b0;
    else     hash_valid <= valid_nxt;
  end
`endif

endmodule

// File: tb/tb_fsm_hash2matrix.sv
// Directed self-checking bench for fsm_hash2matrix with a queue-modelled FWFT FIFO.
module tb_fsm_hash2matrix;

  localparam logic [63:0] HDR = 64'h8000000000000100;
`ifdef HASH2MATRIX_SKID_EN
  localparam int SKID = 1;
`else
  localparam int SKID = 0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         fifo_empty;
  logic [63:0]  fifo_dout;
  logic         fifo_rd_en;
  logic         hash_valid;
  logic         hash_ready;
  logic [255:0] hash_dout;
  logic         hdr_err;

  always #5 clk = ~clk;

  fsm_hash2matrix dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_rd_en (fifo_rd_en),
    .hash_valid (hash_valid),
    .hash_ready (hash_ready),
    .hash_dout  (hash_dout),
    .hdr_err    (hdr_err)
  );

  logic [63:0]  fifo_q[$];
  logic [255:0] got[$];
  int           gotc[$];
  logic         bubble, bubble_mode;
  int           cyc, pops, errs, vcyc, viol;
  logic         s_valid, s_rd;
  logic [255:0] s_dout;
  int           total = 0;
  int           bad   = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    fifo_empty = bubble || (fifo_q.size() == 0);
    fifo_dout  = (fifo_q.size() != 0) ? fifo_q[0] : 64'h0;
  endtask

  task automatic push_frame(input logic [63:0] a, b, c, d);
    fifo_q.push_back(HDR);
    fifo_q.push_back(a);
    fifo_q.push_back(b);
    fifo_q.push_back(c);
    fifo_q.push_back(d);
    drive();
  endtask

  task automatic clear_stats();
    got.delete();
    gotc.delete();
    pops = 0;
    errs = 0;
    vcyc = 0;
  endtask

  // one clock: sample the cycle's outputs, pass the edge, then update the FIFO model
  task automatic step();
    #1;
    s_valid = hash_valid;
    s_dout  = hash_dout;
    s_rd    = fifo_rd_en;
    if (fifo_rd_en && fifo_empty) viol++;
    if (fifo_rd_en) pops++;
    if (hdr_err) errs++;
    if (hash_valid) vcyc++;
    if (hash_valid && hash_ready) begin
      got.push_back(hash_dout);
      gotc.push_back(cyc);
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (s_rd && fifo_q.size() != 0) void'(fifo_q.pop_front());
    if (bubble_mode) bubble = ~bubble;
    drive();
  endtask

  task automatic wait_hashes(input int n, input int budget, input string tag);
    int k = 0;
    while (got.size() < n && k < budget) begin
      step();
      k++;
    end
    check(tag, 256'(got.size()), 256'(n));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [255:0] ref_dout;
    int           unstable, pops0;
    rst = 1'b1; hash_ready = 1'b1; bubble = 1'b0; bubble_mode = 1'b0;
    cyc = 0; viol = 0;
    clear_stats();
    fifo_q.push_back(64'h0123456789ABCDEF);
    drive();

    // reset state, including no pop while held in reset with a non-empty FIFO
    @(posedge clk); @(negedge clk); #1;
    check("rst_valid", 256'(hash_valid), 256'(0));
    check("rst_dout",  hash_dout, 256'h0);
    check("rst_rd_en", 256'(fifo_rd_en), 256'(0));
    check("rst_hdr_err", 256'(hdr_err), 256'(0));
    @(negedge clk);
    fifo_q.delete();
    drive();
    rst = 1'b0;

    // single frame
    clear_stats();
    push_frame(64'h1111111111111111, 64'h2222222222222222, 64'h3333333333333333, 64'h4444444444444444);
    wait_hashes(1, 20, "single_count");
    repeat (3) step();
    check("single_dout", got[0], {64'h1111111111111111, 64'h2222222222222222,
                                  64'h3333333333333333, 64'h4444444444444444});
    check("single_pops", 256'(pops), 256'(5));
    check("single_vcyc", 256'(vcyc), 256'(1));
    check("single_errs", 256'(errs), 256'(0));

    // bad header then a valid frame
    clear_stats();
    fifo_q.push_back(64'hDEADBEEF00000000);
    push_frame(64'hAAAAAAAAAAAAAAAA, 64'hBBBBBBBBBBBBBBBB, 64'hCCCCCCCCCCCCCCCC, 64'hDDDDDDDDDDDDDDDD);
    wait_hashes(1, 20, "badhdr_count");
    check("badhdr_errs", 256'(errs), 256'(1));
    check("badhdr_pops", 256'(pops), 256'(6));
    check("badhdr_dout", got[0], {64'hAAAAAAAAAAAAAAAA, 64'hBBBBBBBBBBBBBBBB,
                                  64'hCCCCCCCCCCCCCCCC, 64'hDDDDDDDDDDDDDDDD});

    // backpressure with the next frame already queued
    clear_stats();
    hash_ready = 1'b0;
    push_frame(64'h0000000000000001, 64'h0000000000000002, 64'h0000000000000003, 64'h0000000000000004);
    push_frame(64'h1000000000000000, 64'h2000000000000000, 64'h3000000000000000, 64'h4000000000000000);
    s_valid = 1'b0;
    for (int k = 0; k < 20 && !s_valid; k++) step();
    check("bp_valid_seen", 256'(s_valid), 256'(1));
    ref_dout = s_dout;
    unstable = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (!s_valid || s_dout !== ref_dout || (SKID == 0 && s_rd)) unstable++;
    end
    check("bp_stable", 256'(unstable), 256'(0));
    check("bp_pops", 256'(pops), 256'(SKID ? 10 : 5));
    check("bp_held", ref_dout, {64'h1, 64'h2, 64'h3, 64'h4});
    hash_ready = 1'b1;
    wait_hashes(2, 30, "bp_count");
    check("bp_first",  got[0], {64'h1, 64'h2, 64'h3, 64'h4});
    check("bp_second", got[1], {64'h1000000000000000, 64'h2000000000000000,
                                64'h3000000000000000, 64'h4000000000000000});

    // FIFO bubbles every other cycle
    clear_stats();
    push_frame(64'h5555555555555555, 64'h6666666666666666, 64'h7777777777777777, 64'h8888888888888888);
    bubble_mode = 1'b1;
    wait_hashes(1, 30, "bubble_count");
    bubble_mode = 1'b0;
    bubble = 1'b0;
    drive();
    check("bubble_dout", got[0], {64'h5555555555555555, 64'h6666666666666666,
                                  64'h7777777777777777, 64'h8888888888888888});
    check("bubble_pops", 256'(pops), 256'(5));
    check("no_pop_when_empty", 256'(viol), 256'(0));

    // asynchronous reset after header + 2 data words
    clear_stats();
    push_frame(64'h9999999999999999, 64'h7777777777777777, 64'hEEEEEEEEEEEEEEEE, 64'hFFFFFFFFFFFFFFFF);
    for (int k = 0; k < 10 && pops < 3; k++) step();
    check("mid_pops", 256'(pops), 256'(3));
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", 256'(hash_valid), 256'(0));
    check("mid_rst_dout",  hash_dout, 256'h0);
    check("mid_rst_rd_en", 256'(fifo_rd_en), 256'(0));
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    fifo_q.delete();
    clear_stats();
    push_frame(64'h0102030405060708, 64'h1112131415161718, 64'h2122232425262728, 64'h3132333435363738);
    wait_hashes(1, 20, "postrst_count");
    check("postrst_dout", got[0], {64'h0102030405060708, 64'h1112131415161718,
                                   64'h2122232425262728, 64'h3132333435363738});

    // back-to-back frames; a header-valued word inside a frame is plain data
    clear_stats();
    push_frame(64'hA1, 64'hA2, 64'hA3, 64'hA4);
    push_frame(64'hB1, HDR, 64'hB3, 64'hB4);
    push_frame(64'hC1, 64'hC2, 64'hC3, 64'hC4);
    wait_hashes(3, 40, "b2b_count");
    check("b2b_h0", got[0], {64'hA1, 64'hA2, 64'hA3, 64'hA4});
    check("b2b_h1", got[1], {64'hB1, HDR, 64'hB3, 64'hB4});
    check("b2b_h2", got[2], {64'hC1, 64'hC2, 64'hC3, 64'hC4});
    check("b2b_gap01", 256'(gotc[1] - gotc[0]), 256'(SKID ? 5 : 6));
    check("b2b_gap12", 256'(gotc[2] - gotc[1]), 256'(SKID ? 5 : 6));
    check("b2b_errs", 256'(errs), 256'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
